pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 129 ++++++++++++
 tb/tb_pc_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: sequential PC stepping plus branch/jump/register-jump redirection with a one-cycle delay slot.
// Optional feature: define BRANCH_DELAY_SLOT_EN to let the pc+4 instruction execute instead of flushing it.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        instr_valid,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic [25:0] jump_index,
    input  logic [15:0] branch_offset,
    input  logic [31:0] reg_target,
    output logic [31:0] pc,
    output logic        redirect,
    output logic        flush,
    output logic        busy,
    output logic        addr_error,
    output logic [7:0]  err_count
);

    typedef enum logic {
        ST_FETCH    = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic FLUSH_ON_REDIRECT = 1'b0;
`else
    localparam logic FLUSH_ON_REDIRECT = 1'b1;
`endif

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic        r_redirect;
    logic        r_flush;
    logic        r_addr_error;
    logic [7:0]  r_err_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_target;
    logic        w_take;
    logic        w_misaligned;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign w_jump_target   = {w_pc_plus4[31:28], jump_index, 2'b00};

    // Transfer decode: register jump outranks direct jump, which outranks branch
    always_comb begin
        w_take       = jump_reg | jump | (branch & branch_taken);
        w_misaligned = jump_reg & (reg_target[1:0] != 2'b00);
        w_target     = w_branch_target;
        if (jump_reg) begin
            w_target = reg_target;
        end else if (jump) begin
            w_target = w_jump_target;
        end else begin
            w_target = w_branch_target;
        end
    end

    // Sequencer state, PC, pending target and registered pulse outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_target     <= 32'h0000_0000;
            r_redirect   <= 1'b0;
            r_flush      <= 1'b0;
            r_addr_error <= 1'b0;
            r_err_count  <= 8'd0;
        end else if (stall) begin
            r_redirect   <= 1'b0;
            r_flush      <= 1'b0;
            r_addr_error <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_pc       <= w_pc_plus4;
                    r_redirect <= 1'b0;
                    r_flush    <= 1'b0;
                    if (instr_valid && w_take && w_misaligned) begin
                        r_addr_error <= 1'b1;
                        if (r_err_count != 8'd255) begin
                            r_err_count <= r_err_count + 8'd1;
                        end else begin
                            r_err_count <= r_err_count;
                        end
                    end else if (instr_valid && w_take) begin
                        r_addr_error <= 1'b0;
                        r_target     <= w_target;
                        r_state      <= ST_REDIRECT;
                    end else begin
                        r_addr_error <= 1'b0;
                    end
                end
                // Delay slot: control inputs are ignored while the target is applied
                ST_REDIRECT: begin
                    r_pc         <= r_target;
                    r_redirect   <= 1'b1;
                    r_flush      <= FLUSH_ON_REDIRECT;
                    r_addr_error <= 1'b0;
                    r_state      <= ST_FETCH;
                end
                default: begin
                    r_state      <= ST_FETCH;
                    r_redirect   <= 1'b0;
                    r_flush      <= 1'b0;
                    r_addr_error <= 1'b0;
                end
            endcase
        end
    end

    assign pc         = r_pc;
    assign redirect   = r_redirect;
    assign flush      = r_flush;
    assign busy       = (r_state == ST_REDIRECT);
    assign addr_error = r_addr_error;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_pc_sequencer;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset, stall, instr_valid, jump, jump_reg, branch, branch_taken;
    logic [25:0] jump_index;
    logic [15:0] branch_offset;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic        redirect, flush, busy, addr_error;
    logic [7:0]  err_count;

    pc_sequencer #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .instr_valid(instr_valid),
        .jump(jump), .jump_reg(jump_reg), .branch(branch), .branch_taken(branch_taken),
        .jump_index(jump_index), .branch_offset(branch_offset), .reg_target(reg_target),
        .pc(pc), .redirect(redirect), .flush(flush), .busy(busy),
        .addr_error(addr_error), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: current pc, queue of pending redirect targets, error tally
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    int          m_err;
    bit          m_red, m_flush, m_aerr;

    typedef struct {
        bit          rst, st, v, j, jr, br, bt;
        logic [25:0] idx;
        logic [15:0] off;
        logic [31:0] rt;
        logic [31:0] epc;
        bit          ered, ebusy, eaerr;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit st, bit v, bit j, bit jr, bit br, bit bt,
                                logic [25:0] idx, logic [15:0] off, logic [31:0] rt,
                                logic [31:0] epc, bit ered, bit ebusy, bit eaerr);
        vec_t t;
        t.rst = rst; t.st = st; t.v = v; t.j = j; t.jr = jr; t.br = br; t.bt = bt;
        t.idx = idx; t.off = off; t.rt = rt;
        t.epc = epc; t.ered = ered; t.ebusy = ebusy; t.eaerr = eaerr;
        return t;
    endfunction

    function automatic vec_t idle(logic [31:0] epc, bit ered);
        return mk(0, 0, 0, 0, 0, 0, 0, 26'd0, 16'd0, 32'd0, epc, ered, 0, 0);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        reset = t.rst; stall = t.st; instr_valid = t.v; jump = t.j; jump_reg = t.jr;
        branch = t.br; branch_taken = t.bt; jump_index = t.idx;
        branch_offset = t.off; reg_target = t.rt;
    endtask

    task automatic model_step();
        logic [31:0] nxt;
        m_red = 0; m_flush = 0; m_aerr = 0;
        if (reset) begin
            m_pc = RPC; m_q.delete(); m_err = 0;
        end else if (stall) begin
            m_red = 0;
        end else if (m_q.size() > 0) begin
            m_pc = m_q.pop_front();
            m_red = 1; m_flush = !DS;
        end else begin
            nxt = m_pc + 32'd4;
            if (instr_valid) begin
                if (jump_reg) begin
                    if (reg_target[1:0] != 2'b00) begin
                        m_aerr = 1;
                        m_err = (m_err + 1 > 255) ? 255 : m_err + 1;
                    end else m_q.push_back(reg_target);
                end else if (jump) begin
                    m_q.push_back({nxt[31:28], jump_index, 2'b00});
                end else if (branch && branch_taken) begin
                    m_q.push_back(nxt + 32'($signed(branch_offset)) * 32'd4);
                end
            end
            m_pc = nxt;
        end
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        #1;
        model_step();
        chk({tag, " pc"},         pc,                m_pc);
        chk({tag, " redirect"},   {31'd0, redirect}, {31'd0, m_red});
        chk({tag, " flush"},      {31'd0, flush},    {31'd0, m_flush});
        chk({tag, " busy"},       {31'd0, busy},     {31'd0, m_q.size() > 0});
        chk({tag, " addr_error"}, {31'd0, addr_error}, {31'd0, m_aerr});
        chk({tag, " err_count"},  {24'd0, err_count}, m_err);
    endtask

    initial begin
        vec_t t;
        t = idle(RPC, 0);
        drive(t);
        m_pc = 32'd0; m_err = 0;

        // Directed table: reset, branch, jump, priority, stall, reset-in-redirect, bad JR, wrap
        vecs.push_back(mk(1,0,0,0,0,0,0, 26'd0, 16'd0, 32'd0, RPC, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 26'd0, 16'd0, 32'd0, RPC, 0,0,0));
        for (int i = 1; i <= 4; i++) vecs.push_back(idle(RPC + 32'(4*i), 0));
        vecs.push_back(mk(0,0,1,0,0,1,1, 26'd0, 16'hFFFC, 32'd0, 32'h0040_0014, 0,1,0));
        vecs.push_back(mk(0,0,1,1,0,0,0, 26'h3FF_FFFF, 16'd0, 32'd0, 32'h0040_0004, 1,0,0));
        for (int i = 2; i <= 8; i++) vecs.push_back(idle(RPC + 32'(4*i), 0));
        vecs.push_back(mk(0,0,1,1,0,0,0, 26'h010_0008, 16'd0, 32'd0, 32'h0040_0024, 0,1,0));
        vecs.push_back(idle(32'h0040_0020, 1));
        vecs.push_back(mk(0,0,1,1,1,1,1, 26'h000_0010, 16'h0040, 32'h0040_0100, 32'h0040_0024, 0,1,0));
        vecs.push_back(idle(32'h0040_0100, 1));
        vecs.push_back(mk(0,0,1,1,0,0,0, 26'h010_0080, 16'd0, 32'd0, 32'h0040_0104, 0,1,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1,1,1,0,0,0, 26'h000_0001, 16'd0, 32'd0, 32'h0040_0104, 0,1,0));
        vecs.push_back(idle(32'h0040_0200, 1));
        vecs.push_back(mk(0,0,1,1,0,0,0, 26'h010_0080, 16'd0, 32'd0, 32'h0040_0204, 0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 26'd0, 16'd0, 32'd0, RPC, 0,0,0));
        vecs.push_back(idle(32'h0040_0004, 0));
        vecs.push_back(mk(0,0,1,0,1,0,0, 26'd0, 16'd0, 32'h0040_0102, 32'h0040_0008, 0,0,1));
        vecs.push_back(mk(0,0,1,0,1,0,0, 26'd0, 16'd0, 32'hFFFF_FFF8, 32'h0040_000C, 0,1,0));
        vecs.push_back(idle(32'hFFFF_FFF8, 1));
        vecs.push_back(idle(32'hFFFF_FFFC, 0));
        vecs.push_back(idle(32'h0000_0000, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i]);
            cycle(tag);
            chk({tag, " tbl_pc"},    pc,                  vecs[i].epc);
            chk({tag, " tbl_red"},   {31'd0, redirect},   {31'd0, vecs[i].ered});
            chk({tag, " tbl_flush"}, {31'd0, flush},      {31'd0, vecs[i].ered & !DS});
            chk({tag, " tbl_busy"},  {31'd0, busy},       {31'd0, vecs[i].ebusy});
            chk({tag, " tbl_aerr"},  {31'd0, addr_error}, {31'd0, vecs[i].eaerr});
        end
        chk("tbl err_count", {24'd0, err_count}, 32'd1);

        // Misaligned JR repeated until the counter saturates
        for (int i = 0; i < 300; i++) begin
            drive(mk(0,0,1,0,1,0,0, 26'd0, 16'd0, 32'h0040_0102, 32'd0, 0,0,0));
            cycle("badjr");
        end
        chk("badjr saturated", {24'd0, err_count}, 32'd255);
        drive(mk(0,1,1,0,1,0,0, 26'd0, 16'd0, 32'h0040_0103, 32'd0, 0,0,0));
        cycle("badjr stalled");

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            t.rst = ($urandom_range(0, 99) == 0);
            t.st  = ($urandom_range(0, 4) == 0);
            t.v   = ($urandom_range(0, 3) != 0);
            t.j   = ($urandom_range(0, 3) == 0);
            t.jr  = ($urandom_range(0, 4) == 0);
            t.br  = ($urandom_range(0, 2) == 0);
            t.bt  = $urandom_range(0, 1);
            t.idx = 26'($urandom);
            t.off = 16'($urandom);
            t.rt  = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) t.rt[1:0] = 2'($urandom_range(1, 3));
            drive(t);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
